// File: rtl/adler32_pkg.sv
`default_nettype none
// ==================================================================
// adler32_pkg : shared Adler-32 types and constants
// Rev 1.0
// ==================================================================
package adler32_pkg;

   typedef logic [15:0] adler_word_t;
   typedef logic [31:0] adler_sum_t;

   localparam adler_word_t ADLER_MOD    = 16'hFFF1;
   localparam adler_word_t ADLER_INIT_A = 16'h0001;
   localparam adler_word_t ADLER_INIT_B = 16'h0000;

endpackage
`default_nettype wire

// File: rtl/adler32_mod_add.sv
`default_nettype none
// ==================================================================
// adler32_mod_add : combinational (x + y) mod MOD, both operands < MOD
// Rev 1.0
// ==================================================================
module adler32_mod_add
   import adler32_pkg::*;
#(
   parameter int unsigned MOD = 32'(ADLER_MOD)
)
(
   input  adler_word_t x,
   input  adler_word_t y,
   output adler_word_t sum
);

   localparam logic [16:0] c_mod = 17'(MOD);

   logic [16:0] w_raw;
   logic        w_wrap;

   // Operands are already reduced, so one conditional subtract brings the sum below MOD.
   assign w_raw  = {1'b0, x} + {1'b0, y};
   assign w_wrap = (w_raw >= c_mod);
   assign sum    = w_wrap ? 16'(w_raw - c_mod) : w_raw[15:0];

endmodule
`default_nettype wire

// File: rtl/adler32_stream.sv
`default_nettype none
// ==================================================================
// adler32_stream : byte-serial Adler-32 with valid/ready in and out
// Rev 1.0
// ==================================================================
module adler32_stream
   import adler32_pkg::*;
#(
   parameter int          LEN_W = 32,
   parameter int unsigned MOD   = 32'(ADLER_MOD)
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_data,
   output logic [LEN_W-1:0] out_len
);

   adler_word_t      r_a;
   adler_word_t      r_b;
   logic [LEN_W-1:0] r_cnt;
   logic             r_out_valid;
   adler_sum_t       r_out_data;
   logic [LEN_W-1:0] r_out_len;

   adler_word_t      w_a_next;
   adler_word_t      w_b_next;
   logic [LEN_W-1:0] w_cnt_inc;
   logic             w_in_fire;
   logic             w_out_fire;

   adler32_mod_add #(.MOD(MOD)) u_add_a (
      .x   (r_a),
      .y   ({8'h00, in_data}),
      .sum (w_a_next)
   );

   adler32_mod_add #(.MOD(MOD)) u_add_b (
      .x   (r_b),
      .y   (w_a_next),
      .sum (w_b_next)
   );

   // A held result blocks input unless it is being consumed in this same cycle.
   assign in_ready   = !r_out_valid || out_ready;
   assign w_in_fire  = in_valid && in_ready;
   assign w_out_fire = r_out_valid && out_ready;
   assign w_cnt_inc  = r_cnt + LEN_W'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a         <= ADLER_INIT_A;
         r_b         <= ADLER_INIT_B;
         r_cnt       <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_len   <= '0;
      end else if (w_in_fire && in_last) begin
         r_out_data  <= {w_b_next, w_a_next};
         r_out_len   <= w_cnt_inc;
         r_out_valid <= 1'b1;
         r_a         <= ADLER_INIT_A;
         r_b         <= ADLER_INIT_B;
         r_cnt       <= '0;
      end else begin
         if (w_in_fire) begin
            r_a   <= w_a_next;
            r_b   <= w_b_next;
            r_cnt <= w_cnt_inc;
         end
         if (w_out_fire) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_len   = r_out_len;

endmodule
`default_nettype wire

// File: tb/tb_adler32_stream.sv
`default_nettype none
// ==================================================================
// tb_adler32_stream : directed + scoreboard bench for adler32_stream
// Rev 1.0
// ==================================================================
module tb_adler32_stream;

   localparam int LEN_W = 32;

   logic             clk       = 1'b0;
   logic             rst       = 1'b0;
   logic             in_valid  = 1'b0;
   logic [7:0]       in_data   = 8'h00;
   logic             in_last   = 1'b0;
   logic             out_ready = 1'b0;
   logic             in_ready;
   logic             out_valid;
   logic [31:0]      out_data;
   logic [LEN_W-1:0] out_len;

   int n_pass  = 0;
   int n_total = 0;
   logic [63:0] sb_q[$];

   always #5 clk = ~clk;

   adler32_stream #(.LEN_W(LEN_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_len   (out_len)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [31:0] adler_ref(input logic [7:0] m[$]);
      int unsigned a = 1;
      int unsigned b = 0;
      foreach (m[i]) begin
         a = (a + 32'(m[i])) % 65521;
         b = (b + a) % 65521;
      end
      return {b[15:0], a[15:0]};
   endfunction

   // Called at a falling edge; returns at the falling edge after the byte is taken.
   task automatic send_byte(input logic [7:0] d, input logic last);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      for (int t = 0; t < 200; t++) begin
         #1;
         if (in_ready) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_last  = 1'b0;
            return;
         end
         @(negedge clk);
      end
      check("send_timeout", {63'd0, in_ready}, 64'd1);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic send_msg(input logic [7:0] m[$], input bit bubbles);
      foreach (m[i]) begin
         if (bubbles && $urandom_range(0, 2) == 0) begin
            in_valid = 1'b0;
            in_data  = 8'hEE;
            in_last  = 1'b1;
            repeat ($urandom_range(1, 3)) @(negedge clk);
         end
         send_byte(m[i], i == m.size() - 1);
      end
   endtask

   // Output monitor: pops the scoreboard on every output handshake.
   initial begin
      logic [63:0] exp;
      forever begin
         @(negedge clk);
         #2;
         if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               check("unexpected_output", 64'(sb_q.size()), 64'd1);
            end else begin
               exp = sb_q.pop_front();
               check("result", {out_data, out_len}, exp);
            end
         end
      end
   end

   initial begin
      logic [7:0] msg[$];

      #1 rst = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      check("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("rst_out_data", {32'd0, out_data}, 64'd0);
      check("rst_out_len", {32'd0, out_len}, 64'd0);
      check("rst_in_ready", {63'd0, in_ready}, 64'd1);
      @(negedge clk);
      rst       = 1'b0;
      out_ready = 1'b1;

      // single byte 'a', result one cycle after the transfer
      sb_q.push_back({32'h00620062, 32'd1});
      send_byte(8'h61, 1'b1);
      #1;
      check("latency_valid", {63'd0, out_valid}, 64'd1);
      @(negedge clk);

      msg = '{8'h61, 8'h62, 8'h63};
      sb_q.push_back({32'h024D0127, 32'd3});
      send_msg(msg, 1'b0);

      msg = '{8'h57, 8'h69, 8'h6B, 8'h69, 8'h70, 8'h65, 8'h64, 8'h69, 8'h61};
      sb_q.push_back({32'h11E60398, 32'd9});
      send_msg(msg, 1'b1);

      msg.delete();
      repeat (300) msg.push_back(8'hFF);
      sb_q.push_back({32'hB90F2AE4, 32'd300});
      send_msg(msg, 1'b0);

      msg.delete();
      for (int i = 0; i < 37; i++) msg.push_back(8'($urandom));
      sb_q.push_back({adler_ref(msg), 32'd37});
      send_msg(msg, 1'b1);
      repeat (3) @(negedge clk);

      // backpressure: hold a result for five cycles
      out_ready = 1'b0;
      sb_q.push_back({32'h00620062, 32'd1});
      send_byte(8'h61, 1'b1);
      repeat (5) begin
         #1;
         check("stall_in_ready", {63'd0, in_ready}, 64'd0);
         check("stall_out_data", {32'd0, out_data}, {32'd0, 32'h00620062});
         @(negedge clk);
      end
      sb_q.push_back({32'h024D0127, 32'd3});
      fork
         begin
            msg = '{8'h61, 8'h62, 8'h63};
            send_msg(msg, 1'b0);
         end
         begin
            repeat (2) @(negedge clk);
            out_ready = 1'b1;
         end
      join
      // last byte accepted in the same cycle as the output handshake
      sb_q.push_back({32'h00620062, 32'd1});
      send_byte(8'h61, 1'b1);
      #1;
      check("b2b_valid", {63'd0, out_valid}, 64'd1);
      check("b2b_data", {32'd0, out_data}, {32'd0, 32'h00620062});
      @(negedge clk);
      sb_q.push_back({32'h00630063, 32'd1});
      send_byte(8'h62, 1'b1);
      repeat (2) @(negedge clk);

      // async reset drops a pending result
      out_ready = 1'b0;
      send_byte(8'h7A, 1'b1);
      #3 rst = 1'b1;
      #1;
      check("rst_drop_valid", {63'd0, out_valid}, 64'd0);
      check("rst_drop_data", {32'd0, out_data}, 64'd0);
      @(negedge clk);
      rst       = 1'b0;
      out_ready = 1'b1;

      // async reset discards a partial message
      send_byte(8'h10, 1'b0);
      send_byte(8'h20, 1'b0);
      #3 rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      sb_q.push_back({32'h00620062, 32'd1});
      send_byte(8'h61, 1'b1);

      for (int t = 0; t < 100 && sb_q.size() != 0; t++) @(negedge clk);
      check("drain", 64'(sb_q.size()), 64'd0);
      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
